hilo_sequencer: RTL and testbench

Sequencer and HI/LO register bank sitting directly upstream of the multi-cycle multiplier and divider engines. It accepts MULT/DIV/MTHI/MTLO/MFHI/MFLO requests from the control unit and launches the engine with a one-cycle start pulse and stable operands. It waits for the engine's completion flag, then captures the 64-bit result into HI/LO. It stalls the control unit through `busy` and serves HI/LO reads.

---
 rtl/hilo_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_hilo_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_sequencer.sv
// hilo_sequencer: launches the multi-cycle multiplier/divider engines with a
// single start pulse and stable operands. It waits for a fresh completion
// flag and captures the 64-bit result into the HI/LO pair. It stalls the
// control unit through busy, serves MTHI/MTLO/MFHI/MFLO in one cycle, and
// keeps sticky divide-by-zero and timeout flags.
module hilo_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              mult_start,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_div0,
  output logic              err_timeout,
  input  logic              err_clr
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  typedef enum logic {
    SEL_MULT = 1'b0,
    SEL_DIV  = 1'b1
  } sel_t;

  state_t             state;
  sel_t               sel;
  logic [CNT_W-1:0]   cnt;

  logic               sel_done;
  logic [DATA_W-1:0]  sel_hi;
  logic [DATA_W-1:0]  sel_lo;
  logic               timeout_hit;

  // Route the active engine's completion flag and result; the other engine
  // is ignored entirely.
  assign sel_done    = (sel == SEL_DIV) ? div_done : mult_done;
  assign sel_hi      = (sel == SEL_DIV) ? div_hi   : mult_hi;
  assign sel_lo      = (sel == SEL_DIV) ? div_lo   : mult_lo;

  // The cycle whose edge would bring the counter to TIMEOUT is the last one
  // allowed in ARM/WAIT; >= keeps the abort reachable even if it is skipped.
  assign timeout_hit = (cnt >= CNT_W'(TIMEOUT - 1));

  assign busy        = (state != S_IDLE);

  // Sequencer FSM with registered engine controls, HI/LO bank, read port and
  // sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sel         <= SEL_MULT;
      cnt         <= '0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      div_start   <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      hi          <= '0;
      lo          <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      err_div0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Start and read strobes are single-cycle unless re-asserted below.
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      rd_valid   <= 1'b0;

      // Clearing comes first so an error raised in this same cycle wins.
      if (err_clr) begin
        err_div0    <= 1'b0;
        err_timeout <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULT: begin
                mult_a     <= op_a;
                mult_b     <= op_b;
                sel        <= SEL_MULT;
                mult_start <= 1'b1;
                state      <= S_LOAD;
              end
              OP_DIV: begin
                if (op_b == '0) begin
                  // Never launch the divider on a zero divisor.
                  err_div0 <= 1'b1;
                end else begin
                  div_a     <= op_a;
                  div_b     <= op_b;
                  sel       <= SEL_DIV;
                  div_start <= 1'b1;
                  state     <= S_LOAD;
                end
              end
              OP_MTHI: hi <= op_a;
              OP_MTLO: lo <= op_a;
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        // Start pulse is visible during this cycle; arm the watchdog.
        S_LOAD: begin
          cnt   <= '0;
          state <= S_ARM;
        end

        // A done still high from the previous operation must not be taken as
        // completion: wait for the engine to drop it first.
        S_ARM: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else if (!sel_done) begin
            state <= S_WAIT;
          end
        end

        // A completion seen on the last permitted cycle still counts.
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (sel_done) begin
            state <= S_WRITE;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end

        // Result bits go into HI/LO verbatim.
        S_WRITE: begin
          hi    <= sel_hi;
          lo    <= sel_lo;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: behavioural multiplier/divider engines
// with programmable restart lag, latency and hang, a vector table of single
// requests, and hand-written multi-cycle corner sequences.
module tb_hilo_sequencer;

  localparam int TIMEOUT = 64;
  localparam int LIMIT   = 300;

  localparam logic [2:0] OP_NOP0 = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mult_start;
  logic [31:0] mult_a, mult_b;
  logic        mult_done = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_done = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic [31:0] hi, lo, rd_data;
  logic        rd_valid, busy, err_div0, err_timeout;
  logic        err_clr = 1'b0;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Engine model configuration, shared by both engines.
  int eng_lag  = 0;
  int eng_lat  = 33;
  bit eng_hang = 1'b0;

  int m_st = 0, m_cnt = 0, d_st = 0, d_cnt = 0;
  int m_pulses = 0, d_pulses = 0;

  logic last_rdv;
  logic last_busy;
  logic last_start;

  hilo_sequencer #(.TIMEOUT(TIMEOUT), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .err_div0(err_div0), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Multiplier model: done stays put for eng_lag edges after start, drops,
  // then rises eng_lat edges later with the product.
  always @(posedge clk) begin
    if (mult_start) begin
      m_pulses <= m_pulses + 1;
      if (eng_lag == 0) begin
        mult_done <= 1'b0;
        m_st      <= 2;
        m_cnt     <= eng_lat;
      end else begin
        m_st  <= 1;
        m_cnt <= eng_lag;
      end
    end else if (m_st == 1) begin
      if (m_cnt == 1) begin
        mult_done <= 1'b0;
        m_st      <= 2;
        m_cnt     <= eng_lat;
      end else m_cnt <= m_cnt - 1;
    end else if (m_st == 2 && !eng_hang) begin
      if (m_cnt == 1) begin
        mult_done          <= 1'b1;
        {mult_hi, mult_lo} <= 64'(mult_a) * 64'(mult_b);
        m_st               <= 0;
      end else m_cnt <= m_cnt - 1;
    end
  end

  // Divider model: same timing, remainder in hi and quotient in lo.
  always @(posedge clk) begin
    if (div_start) begin
      d_pulses <= d_pulses + 1;
      if (eng_lag == 0) begin
        div_done <= 1'b0;
        d_st     <= 2;
        d_cnt    <= eng_lat;
      end else begin
        d_st  <= 1;
        d_cnt <= eng_lag;
      end
    end else if (d_st == 1) begin
      if (d_cnt == 1) begin
        div_done <= 1'b0;
        d_st     <= 2;
        d_cnt    <= eng_lat;
      end else d_cnt <= d_cnt - 1;
    end else if (d_st == 2 && !eng_hang) begin
      if (d_cnt == 1) begin
        div_done <= 1'b1;
        div_hi   <= (div_b == 0) ? 32'hFFFFFFFF : div_a % div_b;
        div_lo   <= (div_b == 0) ? 32'hFFFFFFFF : div_a / div_b;
        d_st     <= 0;
      end else d_cnt <= d_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; snapshot outputs right after it.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid   = 1'b0;
    last_rdv   = rd_valid;
    last_busy  = busy;
    last_start = mult_start | div_start;
  endtask

  // Count samples with busy high, starting at the sample just after accept.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < LIMIT) begin
      n++;
      tick();
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    int k;
    int mp0;
    int dp0;

    vecs[0]  = '{OP_MTLO, 32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0};
    vecs[1]  = '{OP_MFLO, 32'h0,        32'h0,        32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678};
    vecs[2]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32'h0};
    vecs[3]  = '{OP_MFHI, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 1'b1, 32'hFFFFFFFE};
    vecs[4]  = '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32'h0};
    vecs[5]  = '{OP_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32'h0};
    vecs[6]  = '{OP_NOP7, 32'd5,        32'd5,        32'h00000001, 32'h00000000, 1'b0, 32'h0};
    vecs[7]  = '{OP_NOP0, 32'd9,        32'd9,        32'h00000001, 32'h00000000, 1'b0, 32'h0};
    vecs[8]  = '{OP_DIV,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 32'h0};
    vecs[9]  = '{OP_MFLO, 32'h0,        32'h0,        32'h0000000F, 32'h0FFFFFFF, 1'b1, 32'h0FFFFFFF};
    vecs[10] = '{OP_MTHI, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0FFFFFFF, 1'b0, 32'h0};

    // Reset values.
    repeat (3) tick();
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_flags", 64'({busy, rd_valid, mult_start, div_start, err_div0, err_timeout}), 64'(0));
    check("rst_ops", 64'({mult_a, mult_b, div_a, div_b}), 64'(0));
    reset = 1'b0;
    tick();

    // MULT 7x6 with 33-cycle engine: one start pulse, busy for 36 cycles.
    eng_lag = 0;
    eng_lat = 33;
    do_op(OP_MULT, 32'd7, 32'd6);
    check("mul_start_pulse", 64'(mult_start), 64'(1));
    check("mul_operands", 64'({mult_a, mult_b}), {32'd7, 32'd6});
    wait_idle("mul1", n);
    check("mul1_busy_cycles", 64'(n), 64'(36));
    check("mul1_hi", 64'(hi), 64'(0));
    check("mul1_lo", 64'(lo), 64'(42));
    check("mul1_pulses", 64'({m_pulses[15:0], d_pulses[15:0]}), {32'd0, 16'd1, 16'd0});

    // Stale done high from the previous op: ARM must wait for the drop.
    eng_lag = 5;
    eng_lat = 10;
    check("stale_done_high", 64'(mult_done), 64'(1));
    do_op(OP_MULT, 32'd3, 32'd5);
    wait_idle("mul2", n);
    check("mul2_busy_cycles", 64'(n), 64'(18));
    check("mul2_lo", 64'(lo), 64'(15));
    check("mul2_hi", 64'(hi), 64'(0));

    // DIV by zero: error, no engine start, HI/LO unchanged.
    eng_lag = 0;
    eng_lat = 6;
    dp0 = d_pulses;
    do_op(OP_DIV, 32'd17, 32'd0);
    check("div0_busy", 64'(last_busy), 64'(0));
    check("div0_flag", 64'(err_div0), 64'(1));
    repeat (4) tick();
    check("div0_no_start", 64'(d_pulses - dp0), 64'(0));
    check("div0_hilo", {hi, lo}, {32'd0, 32'd15});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("div0_clr", 64'(err_div0), 64'(0));
    // Error raised while err_clr is asserted must stick.
    err_clr = 1'b1;
    do_op(OP_DIV, 32'd17, 32'd0);
    err_clr = 1'b0;
    check("div0_clr_priority", 64'(err_div0), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("div0_clr2", 64'(err_div0), 64'(0));

    // MTHI then MFHI back to back.
    do_op(OP_MTHI, 32'hDEADBEEF, 32'h0);
    check("mthi_hi", 64'(hi), 64'(32'hDEADBEEF));
    check("mthi_busy", 64'(last_busy), 64'(0));
    do_op(OP_MFHI, 32'h0, 32'h0);
    check("mfhi_rdv", 64'(last_rdv), 64'(1));
    check("mfhi_rd", 64'(rd_data), 64'(32'hDEADBEEF));
    check("mfhi_lo", 64'(lo), 64'(15));
    tick();
    check("mfhi_rdv_drop", 64'(rd_valid), 64'(0));
    check("mfhi_rd_hold", 64'(rd_data), 64'(32'hDEADBEEF));

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_rdv", i), 64'(last_rdv), 64'(vecs[i].chk_rd));
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_rd", i), 64'(rd_data), 64'(vecs[i].exp_rd));
      wait_idle($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    end

    // Engine never completes: timeout exactly TIMEOUT cycles after ARM.
    eng_hang = 1'b1;
    mp0 = m_pulses;
    do_op(OP_MULT, 32'd9, 32'd9);
    k = 0;
    while (!err_timeout && k < LIMIT) begin
      tick();
      k++;
    end
    check("tmo_cycles_after_arm", 64'(k - 1), 64'(TIMEOUT));
    check("tmo_busy", 64'(busy), 64'(0));
    check("tmo_hilo", {hi, lo}, {32'hCAFEF00D, 32'h0FFFFFFF});
    check("tmo_one_start", 64'(m_pulses - mp0), 64'(1));
    eng_hang = 1'b0;

    // Reset during WAIT, late done ignored, then a clean MULT 2x2.
    eng_lag = 0;
    eng_lat = 20;
    do_op(OP_MULT, 32'd11, 32'd13);
    repeat (5) tick();
    check("rstw_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_hilo", {hi, lo}, 64'(0));
    check("rstw_flags", 64'({busy, rd_valid, mult_start, div_start, err_div0, err_timeout}), 64'(0));
    check("rstw_ops", 64'({mult_a, mult_b}), 64'(0));
    check("rstw_rd", 64'(rd_data), 64'(0));
    repeat (25) tick();
    check("rstw_late_done", 64'(mult_done), 64'(1));
    check("rstw_ignored", {hi, lo, 31'd0, busy}, 96'(0));
    eng_lat = 4;
    do_op(OP_MULT, 32'd2, 32'd2);
    wait_idle("mul3", n);
    check("mul3_busy_cycles", 64'(n), 64'(7));
    check("mul3_result", {hi, lo}, {32'd0, 32'd4});

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
